receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range is an even value of 4 or more.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clr  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 rcv  input  1  serial line, driven by sender xmt; idles high; asynchronous to clk.
REQ-006 ack  input  1  consumer acknowledge; a high sample consumes the held byte.
REQ-007 data  output  DATA_BITS  received byte; valid while rdy is high.
REQ-008 rdy  output  1  byte available; held until acknowledged.
REQ-009 ferr  output  1  framing-error pulse, one cycle wide.
REQ-010 ovr  output  1  overrun pulse, one cycle wide.

Function
REQ-011 Frame format: start bit 0, DATA_BITS data bits LSB first, stop bit 1 (8N1), one bit per CLKS_PER_BIT cycles.
REQ-012 rcv passes through a 2-flop synchronizer before any use; all timing below refers to the synchronized signal rs.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rs==0 -> START, bit counter cleared, cycle counter loaded to CLKS_PER_BIT/2-1.
REQ-015 START: at counter expiry, rs==0 -> DATA with counter = CLKS_PER_BIT-1; rs==1 -> IDLE (glitch rejected, no output change).
REQ-016 DATA: at each counter expiry, sample rs into shift register bit [index], index increments, counter reloads; after DATA_BITS samples -> STOP.
REQ-017 STOP: at counter expiry, rs==1 -> frame good -> IDLE; rs==0 -> ferr high one cycle, byte discarded -> WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rs==1, then -> IDLE; line break never produces a byte.
REQ-019 Good frame with rdy==0: data loaded and rdy set on the cycle after the stop sample.
REQ-020 Good frame with rdy==1 and ack==0: new byte dropped, data unchanged, ovr high one cycle.
REQ-021 Good frame in the same cycle as ack==1: new byte loaded, rdy stays 1, no ovr.
REQ-022 ack==1 with rdy==1 and no frame completing: rdy clears the next cycle, data holds its value.
REQ-023 ack==1 while rdy==0 is ignored.
REQ-024 Sampling is mid-bit: each sample falls CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles after rs falls.
REQ-025 Reception continues while rdy is high; back-to-back frames with no idle gap are received.
REQ-026 ferr and ovr never assert in the same cycle as each other.

Reset
REQ-027 clr high forces state=IDLE, counters=0, shift register=0, data=0, rdy=0, ferr=0, ovr=0, and synchronizer flops=1 (idle).
REQ-028 clr mid-frame aborts the frame silently, with no ferr and no rdy.
REQ-029 After clr falls, a frame whose start edge came before release is not recognized; reception needs rs high and then a falling edge.
REQ-030 clr has priority over ack and over every FSM transition.

Structure
REQ-031 Package uart_pkg holds the FSM state typedef, START_BIT=0, STOP_BIT=1, and default CLKS_PER_BIT/DATA_BITS constants; sender shares it.
REQ-032 One sub-module, rx_sync, the 2-flop synchronizer with reset value 1; the FSM, counters and output register stay in receiver.

Verification (CLKS_PER_BIT=16, bench drives rcv from sender or a model)
REQ-033 Frame 0xAA, ack held low -> rdy rises 1 cycle after the stop sample (about 154 cycles + 2 sync after the start edge), data=0xAA, ferr=ovr=0.
REQ-034 0x55 then 0x0F back-to-back, ack pulsed after each rdy -> data=0x55, then data=0x0F; rdy drops 1 cycle after each ack.
REQ-035 Two frames with no ack -> data stays at the first byte and ovr pulses once after the second stop sample.
REQ-036 Stop bit forced 0 -> ferr pulses once and rdy stays 0; with rcv held low, no further activity until rcv returns high.
REQ-037 4-cycle low glitch on an idle line -> START aborts to IDLE with no outputs change.
REQ-038 clr pulsed mid-DATA of frame 0xC3 -> all outputs 0, no rdy for that frame; the next clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and its matching sender.
// Holds the FSM state encoding, line-level bit values and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
// Latency: 2 clk; no backpressure.
module rx_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/receiver.sv
// 8N1 serial receiver with mid-bit sampling and a single-byte holding register.
// Latency: byte visible one cycle after the stop sample; no backpressure, a full holding register drops new bytes and pulses ovr.
module receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rcv,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          state;
  logic                 rs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           fill;
  logic                 armed;

  rx_sync u_sync (
    .clk (clk),
    .clr (clr),
    .d   (rcv),
    .q   (rs)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      data  <= '0;
      rdy   <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
      // Synchronizer holds its reset value for two cycles; only a genuine high arms start detection.
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & rs);

      if (ack && rdy)
        rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (armed && rs == START_BIT) begin
            state <= START;
            idx   <= '0;
            cnt   <= HALF;
          end
        end

        START: begin
          if (cnt != '0)
            cnt <= cnt - CW'(1);
          else if (rs == START_BIT) begin
            state <= DATA;
            cnt   <= FULL;
          end else
            state <= IDLE;
        end

        DATA: begin
          if (cnt != '0)
            cnt <= cnt - CW'(1);
          else begin
            shreg[idx] <= rs;
            cnt        <= FULL;
            if (idx == LAST_IDX)
              state <= STOP;
            else
              idx <= idx + IW'(1);
          end
        end

        STOP: begin
          if (cnt != '0)
            cnt <= cnt - CW'(1);
          else if (rs == STOP_BIT) begin
            state <= IDLE;
            // A same-cycle ack frees the holding register for the new byte.
            if (!rdy || ack) begin
              data <= shreg;
              rdy  <= 1'b1;
            end else
              ovr <= 1'b1;
          end else begin
            ferr  <= 1'b1;
            state <= WAIT_HIGH;
          end
        end

        WAIT_HIGH: begin
          if (rs == STOP_BIT)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Randomized self-checking bench for receiver against a frame-level model of the holding register.
module tb_receiver;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       clr;
  logic       rcv;
  logic       ack;
  logic [7:0] data;
  logic       rdy;
  logic       ferr;
  logic       ovr;

  receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk  (clk),
    .clr  (clr),
    .rcv  (rcv),
    .ack  (ack),
    .data (data),
    .rdy  (rdy),
    .ferr (ferr),
    .ovr  (ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  logic rdy_q = 1'b0;

  // Reference model: what the consumer should see, advanced per whole frame / ack.
  logic [7:0] m_data;
  logic       m_rdy;
  int         m_ferr = 0;
  int         m_ovr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
    if (ferr && ovr) both_cnt++;
    if (rdy && !rdy_q) rise_cyc = cyc;
    rdy_q = rdy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rdy"}, 32'(rdy), 32'(m_rdy));
    check({tag, "_data"}, 32'(data), 32'(m_data));
    check({tag, "_ferr"}, ferr_cnt, m_ferr);
    check({tag, "_ovr"}, ovr_cnt, m_ovr);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first 'cut' bit periods of a frame; cut=10 is a whole frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int cut);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < cut; i++) begin
      @(posedge clk);
      #1 rcv = f[i];
      if (i == 0) start_cyc = cyc;
      repeat (CPB - 1) @(posedge clk);
    end
    #1;
  endtask

  task automatic frame_done(input logic [7:0] b);
    if (!m_rdy) begin
      m_data = b;
      m_rdy  = 1'b1;
    end else
      m_ovr++;
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rdy) break;
    end
  endtask

  logic [7:0] b1, b2;
  int gap, extra;
  logic err;

  initial begin
    clr = 1'b1; rcv = 1'b1; ack = 1'b0;
    m_data = 8'h00; m_rdy = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(data), 0);
    check("rst_rdy", 32'(rdy), 0);
    check("rst_ferr", 32'(ferr), 0);
    check("rst_ovr", 32'(ovr), 0);
    @(posedge clk);
    #1 clr = 1'b0;
    tick(10);

    // Single frame, latency of rdy from the start edge
    send_frame(8'hAA, 1'b1, 10);
    frame_done(8'hAA);
    @(negedge clk);
    check_model("aa");
    check("aa_lat", 32'((rise_cyc - start_cyc >= 150) && (rise_cyc - start_cyc <= 160)), 1);

    // Ack clears rdy one cycle later, data holds
    @(posedge clk);
    #1 ack = 1'b1;
    @(negedge clk);
    check("ack_pre_rdy", 32'(rdy), 1);
    @(posedge clk);
    #1 ack = 1'b0;
    m_rdy = 1'b0;
    @(negedge clk);
    check_model("ack");

    // Ack while empty is ignored
    ack_pulse();
    tick(3);
    check_model("ack_idle");

    // Back-to-back frames, consumer acks each
    fork
      begin
        send_frame(8'h55, 1'b1, 10);
        send_frame(8'h0F, 1'b1, 10);
      end
      begin
        wait_rdy();
        check("b2b1_wait", 32'(rdy), 1);
        check("b2b1_data", 32'(data), 32'h55);
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        check("b2b1_drop", 32'(rdy), 0);
        wait_rdy();
        check("b2b2_wait", 32'(rdy), 1);
        check("b2b2_data", 32'(data), 32'h0F);
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        check("b2b2_drop", 32'(rdy), 0);
      end
    join
    m_data = 8'h0F; m_rdy = 1'b0;
    @(negedge clk);
    check_model("b2b");

    // Overrun: two frames, no ack
    b1 = 8'($urandom); b2 = 8'($urandom);
    send_frame(b1, 1'b1, 10); frame_done(b1);
    send_frame(b2, 1'b1, 10); frame_done(b2);
    @(negedge clk);
    check_model("ovr");
    ack_pulse();
    tick(4);

    // Framing error with line held low (break)
    send_frame(8'($urandom), 1'b0, 10);
    m_ferr++;
    tick(200);
    @(negedge clk);
    check_model("brk_hold");
    @(posedge clk);
    #1 rcv = 1'b1;
    tick(10);
    check_model("brk_rel");
    b1 = 8'($urandom);
    send_frame(b1, 1'b1, 10); frame_done(b1);
    @(negedge clk);
    check_model("brk_recover");

    // Short glitch on idle line, rdy left high
    @(posedge clk);
    #1 rcv = 1'b0;
    tick(4);
    rcv = 1'b1;
    tick(200);
    check_model("glitch");

    // clr mid-DATA of 0xC3
    send_frame(8'hC3, 1'b1, 4);
    clr = 1'b1; rcv = 1'b1;
    m_data = 8'h00; m_rdy = 1'b0;
    tick(2);
    @(negedge clk);
    check("clr_data", 32'(data), 0);
    check("clr_rdy", 32'(rdy), 0);
    check("clr_ferr", 32'(ferr), 0);
    check("clr_ovr", 32'(ovr), 0);
    @(posedge clk);
    #1 clr = 1'b0;
    tick(200);
    check_model("clr_after");

    // Line already low across clr release: no frame until a fresh falling edge
    rcv = 1'b0;
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(200);
    check_model("clr_low");
    rcv = 1'b1;
    tick(10);
    check_model("clr_low_rel");

    send_frame(8'h3C, 1'b1, 10); frame_done(8'h3C);
    @(negedge clk);
    check_model("3c");
    ack_pulse();
    tick(4);

    // Random frames, gaps, acks and stop-bit errors
    for (int n = 0; n < 16; n++) begin
      b1  = 8'($urandom);
      err = ($urandom_range(0, 7) == 0);
      send_frame(b1, !err, 10);
      if (err) begin
        m_ferr++;
        extra = $urandom_range(0, 10);
        tick(extra);
        rcv = 1'b1;
        tick(4);
      end else
        frame_done(b1);
      @(negedge clk);
      check_model("rnd");
      gap = $urandom_range(0, 12);
      if (gap >= 2 && $urandom_range(0, 1) == 1) begin
        ack_pulse();
        gap -= 2;
      end
      repeat (gap) @(posedge clk);
    end
    tick(4);
    check_model("rnd_end");
    check("ferr_ovr_same_cycle", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
